// File: rtl/uart_transmit_cfg.sv
// UART transmitter with a configurable data width and runtime-selectable divisor,
// parity and stop-bit count. It can also generate a line break.
// Characters arrive over a ready/valid handshake and leave LSB-first on SOut.
module uart_transmit_cfg #(
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 115_200,
    parameter int DataWidth = 8,
    parameter int DivWidth  = 16
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic [DataWidth-1:0] DataIn,
    input  logic                 DataInValid,
    output logic                 DataInReady,
    input  logic [DivWidth-1:0]  BaudDiv,
    input  logic                 ParityEn,
    input  logic                 ParityOdd,
    input  logic                 TwoStop,
    input  logic                 SendBreak,
    output logic                 SOut,
    output logic                 TxDone,
    output logic                 Busy
);

    localparam int DefaultDiv = ClockFreq / BaudRate;
    // Longest frame is start + data + parity + two stops.
    localparam int FrameMax   = DataWidth + 4;
    localparam int CntW       = $clog2(FrameMax);

    // Refuse to build with a default divisor the divisor datapath cannot hold.
    if (DefaultDiv < 1 || longint'(DefaultDiv) >= (longint'(1) << DivWidth)) begin : g_bad_div
        $error("uart_transmit_cfg: DefaultDiv %0d does not fit in %0d bits", DefaultDiv, DivWidth);
    end
    if (DataWidth < 5 || DataWidth > 9) begin : g_bad_width
        $error("uart_transmit_cfg: DataWidth %0d outside 5..9", DataWidth);
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAME,
        ST_BREAK,
        ST_BREAKEND
    } state_e;

    state_e                state_q, state_d;
    logic [FrameMax-1:0]   shift_q, shift_d;
    logic [DivWidth-1:0]   div_q, div_d;
    logic [DivWidth-1:0]   baud_cnt_q, baud_cnt_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CntW-1:0]       last_bit_q, last_bit_d;
    logic                  done_q, done_d;

    logic [DivWidth-1:0]   eff_div;
    logic [FrameMax-1:0]   frame_load;
    logic [CntW-1:0]       frame_last;
    logic                  baud_tick;

    // Effective divisor: 0 picks the build-time default, 1 is stretched to 2.
    always_comb begin
        eff_div = BaudDiv;
        if (BaudDiv == '0) begin
            eff_div = DivWidth'(DefaultDiv);
        end else if (BaudDiv == DivWidth'(1)) begin
            eff_div = DivWidth'(2);
        end
    end

    // Whole frame image, bit 0 first on the wire; unused upper bits stay 1 as stop bits.
    always_comb begin
        frame_load              = '1;
        frame_load[0]           = 1'b0;
        frame_load[DataWidth:1] = DataIn;
        if (ParityEn) begin
            frame_load[DataWidth+1] = (^DataIn) ^ ParityOdd;
        end
        frame_last = CntW'(DataWidth + 1) + CntW'(ParityEn) + CntW'(TwoStop);
    end

    assign baud_tick = (baud_cnt_q == div_q - DivWidth'(1));

    // State and datapath registers; reset forces the idle-high line immediately.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= ST_IDLE;
            shift_q    <= '1;
            div_q      <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            last_bit_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            last_bit_q <= last_bit_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: accept/break decisions in idle, bit pacing in frame and break end.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        div_d      = div_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        last_bit_d = last_bit_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A pending character wins over a break request.
                if (DataInValid) begin
                    state_d    = ST_FRAME;
                    shift_d    = frame_load;
                    div_d      = eff_div;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    last_bit_d = frame_last;
                end else if (SendBreak) begin
                    state_d    = ST_BREAK;
                    div_d      = eff_div;
                    baud_cnt_d = '0;
                end
            end
            ST_FRAME: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b1, shift_q[FrameMax-1:1]};
                    if (bit_cnt_q == last_bit_q) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + DivWidth'(1);
                end
            end
            ST_BREAK: begin
                if (!SendBreak) begin
                    state_d    = ST_BREAKEND;
                    baud_cnt_d = '0;
                end
            end
            ST_BREAKEND: begin
                // One bit time of mark after the break before taking new work.
                if (baud_tick) begin
                    state_d    = ST_IDLE;
                    baud_cnt_d = '0;
                end else begin
                    baud_cnt_d = baud_cnt_q + DivWidth'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level is decoded from state so reset drives it high without a clock.
    always_comb begin
        SOut = 1'b1;
        case (state_q)
            ST_FRAME: SOut = shift_q[0];
            ST_BREAK: SOut = 1'b0;
            default:  SOut = 1'b1;
        endcase
    end

    assign DataInReady = (state_q == ST_IDLE);
    assign Busy        = ~DataInReady;
    assign TxDone      = done_q;

endmodule

// File: tb/tb_uart_transmit_cfg.sv
// Bench for uart_transmit_cfg: a cycle-level waveform model checks every cycle of the
// 8-bit build, and directed tests pin bit patterns and timings with literal values.
module tb_uart_transmit_cfg;

    logic        Clock;
    logic        ResetN;
    logic [7:0]  DataIn;
    logic        DataInValid;
    logic        DataInReady;
    logic [15:0] BaudDiv;
    logic        ParityEn, ParityOdd, TwoStop, SendBreak;
    logic        SOut, TxDone, Busy;

    logic [4:0]  data5;
    logic        valid5, ready5, brk5, sout5, done5, busy5;

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_on = 0;

    uart_transmit_cfg #(.DataWidth(8)) dut (
        .Clock(Clock), .ResetN(ResetN), .DataIn(DataIn), .DataInValid(DataInValid),
        .DataInReady(DataInReady), .BaudDiv(BaudDiv), .ParityEn(ParityEn),
        .ParityOdd(ParityOdd), .TwoStop(TwoStop), .SendBreak(SendBreak),
        .SOut(SOut), .TxDone(TxDone), .Busy(Busy)
    );

    uart_transmit_cfg #(.DataWidth(5)) dut5 (
        .Clock(Clock), .ResetN(ResetN), .DataIn(data5), .DataInValid(valid5),
        .DataInReady(ready5), .BaudDiv(BaudDiv), .ParityEn(1'b0),
        .ParityOdd(1'b0), .TwoStop(1'b0), .SendBreak(brk5),
        .SOut(sout5), .TxDone(done5), .Busy(busy5)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int eff(input int b);
        return (b == 0) ? 868 : ((b == 1) ? 2 : b);
    endfunction

    // Model: a queue of expected {SOut, Ready, TxDone} values, one per cycle.
    logic [2:0] mq[$];
    logic [2:0] exp_v;
    bit         in_brk;
    int         brk_d;

    always @(posedge Clock or negedge ResetN) begin : model
        logic [2:0] nxt;
        logic       bits_q[$];
        int         d;
        logic       par;
        if (!ResetN) begin
            mq.delete();
            in_brk <= 1'b0;
            exp_v  <= 3'b110;
        end else begin
            nxt = 3'b110;
            if (mq.size() > 0) begin
                nxt = mq.pop_front();
            end else if (in_brk) begin
                if (SendBreak) begin
                    nxt = 3'b000;
                end else begin
                    for (int i = 0; i < brk_d; i++) mq.push_back(3'b100);
                    mq.push_back(3'b110);
                    nxt = mq.pop_front();
                    in_brk <= 1'b0;
                end
            end else if (DataInValid) begin
                d = eff(int'(BaudDiv));
                bits_q.delete();
                bits_q.push_back(1'b0);
                for (int i = 0; i < 8; i++) bits_q.push_back(DataIn[i]);
                par = (($countones(DataIn) % 2) == 1) ^ ParityOdd;
                if (ParityEn) bits_q.push_back(par);
                bits_q.push_back(1'b1);
                if (TwoStop) bits_q.push_back(1'b1);
                foreach (bits_q[k]) begin
                    for (int i = 0; i < d; i++) mq.push_back({bits_q[k], 2'b00});
                end
                mq.push_back(3'b111);
                nxt = mq.pop_front();
            end else if (SendBreak) begin
                in_brk <= 1'b1;
                brk_d  <= eff(int'(BaudDiv));
                nxt = 3'b000;
            end
            exp_v <= nxt;
        end
    end

    // Compare process: every cycle out of reset, DUT outputs against the model.
    always @(negedge Clock) begin
        if (chk_on && ResetN) begin
            chk("m_sout",  longint'(SOut),        longint'(exp_v[2]));
            chk("m_ready", longint'(DataInReady), longint'(exp_v[1]));
            chk("m_done",  longint'(TxDone),      longint'(exp_v[0]));
            chk("m_busy",  longint'(Busy),        longint'(!exp_v[1]));
        end
    end

    // Samples the middle of each bit starting from the current negedge (cycle 0 after
    // the accept edge) until TxDone is seen or the cycle budget expires.
    task automatic capture(input bit use5, input int d, input int limit,
                           output logic [15:0] bits, output int done_at);
        logic s, dn;
        bits    = '1;
        done_at = -1;
        for (int c = 0; c < limit; c++) begin
            s  = use5 ? sout5 : SOut;
            dn = use5 ? done5 : TxDone;
            if ((c % d) == (d / 2) && (c / d) < 16) bits[c / d] = s;
            if (dn) begin
                done_at = c;
                break;
            end
            @(negedge Clock);
        end
    endtask

    // One frame on the 8-bit DUT; configuration is scrambled right after accept.
    task automatic frame8(input logic [7:0] d, input int div, input bit p_en,
                          input bit p_odd, input bit two,
                          output logic [15:0] bits, output int done_at);
        @(negedge Clock);
        DataIn = d; BaudDiv = 16'(div); ParityEn = p_en; ParityOdd = p_odd;
        TwoStop = two; DataInValid = 1'b1;
        @(negedge Clock);
        DataInValid = 1'b0;
        DataIn = ~d; BaudDiv = 16'd3; ParityEn = ~p_en; ParityOdd = ~p_odd; TwoStop = ~two;
        capture(1'b0, eff(div), 20000, bits, done_at);
    endtask

    initial begin : stim
        logic [15:0] bits;
        int at, at2, zeros, highs;
        bit saw_done;

        ResetN = 1'b0; DataIn = '0; DataInValid = 1'b0; BaudDiv = 16'd10;
        ParityEn = 1'b0; ParityOdd = 1'b0; TwoStop = 1'b0; SendBreak = 1'b0;
        data5 = '0; valid5 = 1'b0; brk5 = 1'b0;
        repeat (3) @(negedge Clock);
        ResetN = 1'b1;
        @(negedge Clock);
        chk("rst_sout",  longint'(SOut), 1);
        chk("rst_ready", longint'(DataInReady), 1);
        chk("rst_busy",  longint'(Busy), 0);
        chk("rst_done",  longint'(TxDone), 0);
        chk("rst_ready5", longint'(ready5), 1);
        chk_on = 1'b1;

        // Basic 8N1 frame
        frame8(8'hA5, 10, 0, 0, 0, bits, at);
        chk("a5_bits", longint'(bits[9:0]), longint'(10'h34A));
        chk("a5_done_at", at, 100);
        chk("a5_ready", longint'(DataInReady), 1);

        // Even parity, two stops, then odd parity
        frame8(8'h07, 10, 1, 0, 1, bits, at);
        chk("even_bits", longint'(bits[11:0]), longint'(12'hE0E));
        chk("even_par", longint'(bits[9]), 1);
        chk("even_done_at", at, 120);
        frame8(8'h07, 10, 1, 1, 1, bits, at);
        chk("odd_bits", longint'(bits[11:0]), longint'(12'hC0E));
        chk("odd_par", longint'(bits[9]), 0);
        chk("odd_done_at", at, 120);

        // Back-to-back with a divisor change during the first frame
        @(negedge Clock);
        DataIn = 8'h55; BaudDiv = 16'd10; ParityEn = 0; ParityOdd = 0; TwoStop = 0;
        DataInValid = 1'b1;
        @(negedge Clock);
        DataIn = 8'h0F; BaudDiv = 16'd20;
        capture(1'b0, 10, 2000, bits, at);
        chk("b2b_first_bits", longint'(bits[9:0]), longint'(10'h2AA));
        chk("b2b_first_done", at, 100);
        chk("b2b_idle_ready", longint'(DataInReady), 1);
        chk("b2b_idle_sout", longint'(SOut), 1);
        @(negedge Clock);
        chk("b2b_second_ready", longint'(DataInReady), 0);
        chk("b2b_second_start", longint'(SOut), 0);
        DataInValid = 1'b0;
        capture(1'b0, 20, 2000, bits, at2);
        chk("b2b_second_bits", longint'(bits[9:0]), longint'(10'h21E));
        chk("b2b_second_done", at2, 200);

        // Break for 500 clocks, then one bit time of mark
        @(negedge Clock);
        BaudDiv = 16'd10; SendBreak = 1'b1;
        @(negedge Clock);
        zeros = 0; highs = 0; saw_done = 0;
        for (int c = 0; c < 500; c++) begin
            if (!SOut && !DataInReady) zeros++;
            if (TxDone) saw_done = 1;
            if (c == 499) SendBreak = 1'b0;
            @(negedge Clock);
        end
        BaudDiv = 16'd3;
        for (int c = 500; c < 510; c++) begin
            if (SOut && !DataInReady) highs++;
            if (TxDone) saw_done = 1;
            @(negedge Clock);
        end
        chk("brk_low_cycles", zeros, 500);
        chk("brk_end_cycles", highs, 10);
        chk("brk_ready_after", longint'(DataInReady), 1);
        chk("brk_no_done", longint'(saw_done), 0);

        // Valid and break together: the frame wins, break held during it is ignored
        @(negedge Clock);
        DataIn = 8'hC3; BaudDiv = 16'd10; DataInValid = 1'b1; SendBreak = 1'b1;
        @(negedge Clock);
        DataInValid = 1'b0;
        capture(1'b0, 10, 2000, bits, at);
        SendBreak = 1'b0;
        chk("vb_bits", longint'(bits[9:0]), longint'(10'h386));
        chk("vb_done_at", at, 100);

        // Divisor edge cases
        frame8(8'h3C, 1, 0, 0, 0, bits, at);
        chk("div1_bits", longint'(bits[9:0]), longint'(10'h278));
        chk("div1_done_at", at, 20);
        frame8(8'h81, 0, 0, 0, 0, bits, at);
        chk("div0_bits", longint'(bits[9:0]), longint'(10'h302));
        chk("div0_done_at", at, 8680);

        // 5-bit build
        @(negedge Clock);
        BaudDiv = 16'd10; data5 = 5'h1B; valid5 = 1'b1;
        @(negedge Clock);
        valid5 = 1'b0; data5 = 5'h00;
        capture(1'b1, 10, 2000, bits, at);
        chk("w5_bits", longint'(bits[6:0]), longint'(7'h76));
        chk("w5_done_at", at, 70);
        chk("w5_ready", longint'(ready5), 1);
        chk("w5_busy", longint'(busy5), 0);

        // Reset in the middle of a frame
        @(negedge Clock);
        DataIn = 8'h00; BaudDiv = 16'd10; DataInValid = 1'b1;
        @(negedge Clock);
        DataInValid = 1'b0;
        repeat (35) @(negedge Clock);
        chk("mid_sout_low", longint'(SOut), 0);
        #2 ResetN = 1'b0;
        #1;
        chk("mid_rst_sout", longint'(SOut), 1);
        chk("mid_rst_ready", longint'(DataInReady), 1);
        chk("mid_rst_done", longint'(TxDone), 0);
        repeat (3) @(negedge Clock);
        ResetN = 1'b1;
        repeat (20) @(negedge Clock);
        chk("post_rst_sout", longint'(SOut), 1);
        chk("post_rst_ready", longint'(DataInReady), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_transmit_cfg.md
Name: uart_transmit_cfg

Overview:
Parametrised next-generation UART transmitter with a configurable data width and a runtime-selectable baud divisor, parity mode and stop-bit count. It can also generate a line break. It accepts one character per ready/valid handshake and serialises it LSB-first on SOut. It sits between the CPU-side MMIO/FIFO logic and the serial pin, and replaces the fixed 8N1 transmitter.

Parameters:
ClockFreq, 100_000_000, system clock frequency in Hz
BaudRate, 115_200, default baud rate; DefaultDiv = ClockFreq / BaudRate
DataWidth, 8, data bits per frame; legal range 5..9
DivWidth, 16, width of the runtime baud divisor input

Ports:
Clock  in  1  system clock, rising edge
ResetN  in  1  asynchronous, active-low reset
DataIn  in  DataWidth  character to send, LSB transmitted first
DataInValid  in  1  DataIn is valid
DataInReady  out  1  transmitter can accept a character
BaudDiv  in  DivWidth  clocks per bit; 0 selects DefaultDiv; 1 is treated as 2
ParityEn  in  1  append a parity bit
ParityOdd  in  1  1 selects odd parity, 0 selects even
TwoStop  in  1  1 selects two stop bits, 0 selects one
SendBreak  in  1  request to hold the line low (break)
SOut  out  1  serial line, idles high
TxDone  out  1  one-cycle pulse when a frame's last stop bit completes
Busy  out  1  equals !DataInReady

Behaviour:
- Reset (ResetN low, asynchronous): SOut=1, DataInReady=1, TxDone=0, state IDLE, all counters 0. Assertion in mid-frame aborts the frame and drives SOut high immediately, without waiting for a clock.
- Accept: a transfer occurs on a rising edge where DataInValid && DataInReady. On that edge the block latches DataIn, the effective divisor D, ParityEn, ParityOdd and TwoStop. Input changes after the accept edge have no effect on the frame in flight.
- Frame: N = 1 + DataWidth + ParityEn + (TwoStop ? 2 : 1) bits, sent in this order: start bit (0), data bits LSB-first, optional parity, stop bits (1).
- Parity bit: even parity = XOR of the data bits; odd parity = its inverse.
- Timing: each bit is held for exactly D clocks. SOut shows the start bit from the accept edge onward. DataInReady falls on the accept edge.
- End of frame: on the edge D*N clocks after the accept edge, DataInReady rises, TxDone pulses high for 1 cycle, and SOut stays 1.
- Back-to-back: if DataInValid is held high, the next accept happens on the first edge where Ready=1. That gives exactly 1 extra idle-high clock between frames.
- Baud counter: counts 0..D-1, restarts at the accept edge, and does not run in IDLE.
- Divisor width: DefaultDiv must fit in DivWidth bits; an elaboration-time check fails otherwise.
- State machine:
  - IDLE -> FRAME on accept.
  - IDLE -> BREAK when SendBreak=1 and DataInValid=0. DataInValid takes priority over SendBreak when both are high.
  - FRAME -> IDLE after bit N-1 completes.
  - BREAK: SOut=0, Ready=0, held while SendBreak=1 with no length limit. Latches D on entry.
  - BREAK -> BREAKEND when SendBreak=0.
  - BREAKEND: SOut=1 for exactly D clocks, then -> IDLE with Ready=1. No TxDone pulse for a break.
- SendBreak asserted during FRAME is ignored until the block returns to IDLE.
- Bit counter and shift register are sized for the largest frame: DataWidth+4 bits.

Test Plan:
- Reset sequence: hold ResetN low for 3 cycles, release -> SOut=1, DataInReady=1, Busy=0, TxDone=0. Drive ResetN low mid-frame -> SOut=1 before the next clock edge.
- Basic frame: BaudDiv=10, no parity, one stop, DataIn=8'hA5 -> SOut sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 10 clocks. Ready returns and TxDone pulses 100 clocks after the accept edge.
- Parity and stop bits: BaudDiv=10, ParityEn=1, ParityOdd=0, TwoStop=1, DataIn=8'h07 -> parity bit=1, frame 120 clocks. Repeat with ParityOdd=1 -> parity bit=0.
- Back-to-back and config latching: DataInValid held high with 8'h55 then 8'h0F; change BaudDiv from 10 to 20 mid-frame -> first frame keeps 10-clock bits, second uses 20, exactly 1 idle-high clock between frames.
- Break: with DataInValid low, SendBreak=1 for 500 clocks at BaudDiv=10 -> SOut=0 for 500 clocks, then 10 clocks high, then Ready=1, no TxDone. Assert SendBreak and DataInValid together in IDLE -> the frame is sent first.
- Divisor edge cases: BaudDiv=0 -> DefaultDiv=868 clocks per bit. BaudDiv=1 -> 2 clocks per bit. DataWidth=5 build with DataIn=5'h1B -> 7-bit 8N1-equivalent frame (start, 5 data, 1 stop).
